// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
//
// Instruction-fetch stage of the 5-stage RISC-V pipeline. Owns the PC, runs a
// variable-latency request/ready handshake towards instruction memory, and
// drives the IF/ID pipeline register that the decode stage consumes.
//
// Memory wait states become bubbles in IF/ID. A word that returns while
// decode is stalled is parked in a one-entry hold buffer. A redirect that
// arrives while a request is still outstanding moves the FSM to KILL. KILL
// lets that request finish, drops its data, and then jumps to the target.
//
// Optional feature (compile-time macro FETCH_PERF_EN):
//   When defined, the stage adds perf_fetch_cnt_o and perf_bubble_cnt_o.
//   These are free-running, wrapping 32-bit event counters.
//
// Parameters:
//   RESET_PC   PC loaded on reset
//   NOP_INSTR  bubble encoding written into IF/ID (addi x0,x0,0)
//
// Ports:
//   clk                clock, all state updates on the rising edge
//   rst                asynchronous active-high reset
//   if_id_en_i         1 = decode accepts a new IF/ID value this cycle
//   if_id_flush_i      clear IF/ID to a bubble
//   pc_next_sel_i      branch/jump taken, redirect fetch
//   branch_target_i    redirect target (bits [1:0] ignored)
//   imem_req_o         instruction request valid
//   imem_addr_o        request address (always the PC)
//   imem_rdata_i       instruction word, valid while imem_ready_i=1
//   imem_ready_i       request completes this cycle
//   if_id_pc_o         PC of the instruction in IF/ID
//   if_id_instr_o      instruction in IF/ID
//   if_id_valid_o      IF/ID holds a real instruction
//   fetch_bubble_o     last IF/ID load was a memory-wait bubble
//   perf_fetch_cnt_o   (FETCH_PERF_EN only) count of valid IF/ID loads
//   perf_bubble_cnt_o  (FETCH_PERF_EN only) cycles with fetch_bubble_o set
// ---------------------------------------------------------------------------
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_id_en_i,
    input  logic        if_id_flush_i,
    input  logic        pc_next_sel_i,
    input  logic [31:0] branch_target_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_rdata_i,
    input  logic        imem_ready_i,
    output logic [31:0] if_id_pc_o,
    output logic [31:0] if_id_instr_o,
    output logic        if_id_valid_o,
    output logic        fetch_bubble_o
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetch_cnt_o,
    output logic [31:0] perf_bubble_cnt_o
`endif
);

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,  // request outstanding at pc
        ST_HOLD  = 2'd1,  // fetched word parked, waiting for decode
        ST_KILL  = 2'd2   // request outstanding, but its data is unwanted
    } state_t;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    state_t      state_reg, state_next;
    logic [31:0] pc_reg, pc_next;
    logic [31:0] redir_reg, redir_next;
    logic [31:0] hold_pc_reg, hold_pc_next;
    logic [31:0] hold_instr_reg, hold_instr_next;

    logic [31:0] if_id_pc_reg, if_id_pc_next;
    logic [31:0] if_id_instr_reg, if_id_instr_next;
    logic        if_id_valid_reg, if_id_valid_next;
    logic        fetch_bubble_reg, fetch_bubble_next;

    // Per-cycle IF/ID load decision produced by the FSM
    logic        load_word;    // load {word_pc, word_instr} as a valid entry
    logic        load_bubble;  // load a bubble
    logic        mem_wait;     // the bubble is due to memory latency
    logic [31:0] word_pc;
    logic [31:0] word_instr;

    logic [31:0] target;
    logic [31:0] pc_plus4;

    assign target   = {branch_target_i[31:2], 2'b00};
    assign pc_plus4 = pc_reg + 32'd4;

    // The address is the PC itself. The PC only moves when a request
    // completes or when leaving HOLD, so the address stays stable mid-request.
    assign imem_addr_o = pc_reg;
    assign imem_req_o  = (state_reg != ST_HOLD);

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg        <= ST_FETCH;
            pc_reg           <= RESET_PC;
            redir_reg        <= 32'h0;
            hold_pc_reg      <= 32'h0;
            hold_instr_reg   <= NOP_INSTR;
            if_id_pc_reg     <= 32'h0;
            if_id_instr_reg  <= NOP_INSTR;
            if_id_valid_reg  <= 1'b0;
            fetch_bubble_reg <= 1'b0;
        end else begin
            state_reg        <= state_next;
            pc_reg           <= pc_next;
            redir_reg        <= redir_next;
            hold_pc_reg      <= hold_pc_next;
            hold_instr_reg   <= hold_instr_next;
            if_id_pc_reg     <= if_id_pc_next;
            if_id_instr_reg  <= if_id_instr_next;
            if_id_valid_reg  <= if_id_valid_next;
            fetch_bubble_reg <= fetch_bubble_next;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic. A redirect always takes priority over a capture and
    // over a decode stall.
    // -----------------------------------------------------------------------
    always_comb begin
        state_next      = state_reg;
        pc_next         = pc_reg;
        redir_next      = redir_reg;
        hold_pc_next    = hold_pc_reg;
        hold_instr_next = hold_instr_reg;
        load_word       = 1'b0;
        load_bubble     = 1'b0;
        mem_wait        = 1'b0;
        word_pc         = pc_reg;
        word_instr      = imem_rdata_i;

        case (state_reg)
            ST_FETCH: begin
                if (imem_ready_i) begin
                    if (pc_next_sel_i) begin
                        // Fetched word belongs to the wrong path
                        pc_next     = target;
                        load_bubble = 1'b1;
                    end else if (if_id_en_i) begin
                        load_word = 1'b1;
                        pc_next   = pc_plus4;
                    end else begin
                        // Decode stalled: park the word, stop requesting
                        hold_pc_next    = pc_reg;
                        hold_instr_next = imem_rdata_i;
                        state_next      = ST_HOLD;
                    end
                end else begin
                    if (pc_next_sel_i) begin
                        // Cannot retract the request, so remember where to go
                        redir_next  = target;
                        state_next  = ST_KILL;
                        load_bubble = 1'b1;
                    end else if (if_id_en_i) begin
                        load_bubble = 1'b1;
                        mem_wait    = 1'b1;
                    end
                end
            end

            ST_HOLD: begin
                if (pc_next_sel_i) begin
                    pc_next     = target;
                    state_next  = ST_FETCH;
                    load_bubble = 1'b1;
                end else if (if_id_en_i) begin
                    load_word  = 1'b1;
                    word_pc    = hold_pc_reg;
                    word_instr = hold_instr_reg;
                    pc_next    = pc_plus4;
                    state_next = ST_FETCH;
                end
            end

            ST_KILL: begin
                // Last redirect wins, including one in the completing cycle
                if (pc_next_sel_i) begin
                    redir_next = target;
                end
                if (imem_ready_i) begin
                    pc_next    = pc_next_sel_i ? target : redir_reg;
                    state_next = ST_FETCH;
                end
                // A redirect-induced bubble does not count as a memory wait
                if (pc_next_sel_i || if_id_en_i) begin
                    load_bubble = 1'b1;
                end
            end

            default: begin
                state_next = ST_FETCH;
            end
        endcase

        // Flush only touches IF/ID: a word that would have been loaded is
        // dropped, while the PC and FSM advance as decided above.
        if (if_id_flush_i) begin
            load_word   = 1'b0;
            load_bubble = 1'b1;
            mem_wait    = 1'b0;
        end
    end

    // -----------------------------------------------------------------------
    // IF/ID register next value. It holds unless the FSM asked for a load.
    // -----------------------------------------------------------------------
    always_comb begin
        if_id_pc_next     = if_id_pc_reg;
        if_id_instr_next  = if_id_instr_reg;
        if_id_valid_next  = if_id_valid_reg;
        fetch_bubble_next = fetch_bubble_reg;

        if (load_word) begin
            if_id_pc_next     = word_pc;
            if_id_instr_next  = word_instr;
            if_id_valid_next  = 1'b1;
            fetch_bubble_next = 1'b0;
        end else if (load_bubble) begin
            if_id_pc_next     = 32'h0;
            if_id_instr_next  = NOP_INSTR;
            if_id_valid_next  = 1'b0;
            fetch_bubble_next = mem_wait;
        end
    end

    assign if_id_pc_o     = if_id_pc_reg;
    assign if_id_instr_o  = if_id_instr_reg;
    assign if_id_valid_o  = if_id_valid_reg;
    assign fetch_bubble_o = fetch_bubble_reg;

`ifdef FETCH_PERF_EN
    // -----------------------------------------------------------------------
    // Performance counters (wrapping)
    // -----------------------------------------------------------------------
    logic [31:0] perf_fetch_cnt_reg;
    logic [31:0] perf_bubble_cnt_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetch_cnt_reg  <= 32'h0;
            perf_bubble_cnt_reg <= 32'h0;
        end else begin
            if (load_word) begin
                perf_fetch_cnt_reg <= perf_fetch_cnt_reg + 32'd1;
            end
            if (fetch_bubble_reg) begin
                perf_bubble_cnt_reg <= perf_bubble_cnt_reg + 32'd1;
            end
        end
    end

    assign perf_fetch_cnt_o  = perf_fetch_cnt_reg;
    assign perf_bubble_cnt_o = perf_bubble_cnt_reg;
`endif

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage RISC-V pipeline. Owns the PC, drives a variable-latency instruction-memory request/ready interface, and produces the IF/ID pipeline register consumed by the decode stage.
- Honours the hazard unit's IF/ID enable, the IF/ID flush, and branch redirects resolved in ID.
- Absorbs memory latency by inserting bubbles and memory-ready/stall collisions with a one-entry hold buffer.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, bubble encoding (addi x0,x0,0) written into IF/ID when invalid.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- if_id_en_i  in  1  1 = decode accepts a new IF/ID value this cycle; 0 = IF/ID holds (stall).
- if_id_flush_i  in  1  clear IF/ID to a bubble.
- pc_next_sel_i  in  1  branch/jump taken; redirect fetch to branch_target_i.
- branch_target_i  in  32  redirect target; bits [1:0] are ignored and treated as 0.
- imem_req_o  out  1  instruction request valid.
- imem_addr_o  out  32  request address, equal to the PC.
- imem_rdata_i  in  32  instruction word; valid when imem_ready_i=1.
- imem_ready_i  in  1  request completes this cycle.
- if_id_pc_o  out  32  PC of the instruction in IF/ID.
- if_id_instr_o  out  32  instruction in IF/ID.
- if_id_valid_o  out  1  IF/ID holds a real instruction.
- fetch_bubble_o  out  1  registered; 1 when the last IF/ID load was a bubble caused by memory wait.

Behaviour:
- Reset values (async): pc=RESET_PC, state=FETCH, if_id_pc_o=0, if_id_instr_o=NOP_INSTR, if_id_valid_o=0, fetch_bubble_o=0, hold buffer empty, redirect register=0. Releasing reset makes the first request to RESET_PC in the next cycle.
- Memory protocol:
  - imem_addr_o=pc at all times.
  - imem_req_o=1 in FETCH and KILL, 0 in HOLD.
  - Once raised, req and addr stay stable until imem_ready_i=1. The address never changes mid-request.
  - A zero-wait memory (ready tied high) gives one instruction per cycle.
- FSM states: FETCH, HOLD, KILL.
- FETCH:
  - ready=1, no redirect, if_id_en_i=1:
    - IF/ID <= {pc, rdata, valid=1}.
    - pc <= pc+4 (32-bit wrap: 32'hFFFF_FFFC+4=0).
    - Stay in FETCH.
  - ready=1, no redirect, if_id_en_i=0:
    - Capture {pc, rdata} into the hold buffer.
    - IF/ID unchanged.
    - Go to HOLD.
  - ready=0, if_id_en_i=1:
    - IF/ID <= bubble (pc=0, NOP_INSTR, valid=0).
    - fetch_bubble_o=1.
  - ready=0, if_id_en_i=0: IF/ID holds.
- HOLD:
  - When if_id_en_i=1: IF/ID <= hold buffer with valid=1, pc <= pc+4, go to FETCH.
  - Otherwise stay in HOLD.
- Redirect (pc_next_sel_i=1) overrides the stall and has priority over normal capture:
  - In FETCH with ready=1, or in HOLD: discard the fetched/held word, pc <= target, go to FETCH.
  - In FETCH with ready=0: store the target in the redirect register, go to KILL. The pc and address stay unchanged.
  - In KILL with ready=1: discard rdata, pc <= redirect register, go to FETCH.
  - A new redirect while in KILL overwrites the redirect register (last one wins).
  - On any redirect, IF/ID <= bubble regardless of if_id_en_i.
- if_id_flush_i=1: IF/ID <= bubble regardless of if_id_en_i. The PC and FSM are unaffected unless a redirect is also present.
- Simultaneous flush and valid capture: flush wins for IF/ID. The captured word is dropped and the PC still advances.
- In KILL, IF/ID loads a bubble when if_id_en_i=1.
- Asserting rst mid-request abandons the request immediately. Memory must tolerate a dropped request.

Optional Feature:
- Macro FETCH_PERF_EN.
- Defined:
  - Adds outputs perf_fetch_cnt_o[31:0] and perf_bubble_cnt_o[31:0], both reset to 0 and wrapping.
  - perf_fetch_cnt_o increments on every valid IF/ID load.
  - perf_bubble_cnt_o increments on every cycle fetch_bubble_o is set.
- Undefined: the ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- Reset release, ready tied 1, words 0x00100093/0x00200113/0x00300193 -> IF/ID shows PCs 0x0, 0x4, 0x8 in consecutive cycles, valid=1.
- Ready low 2 cycles on PC 0x4, if_id_en_i=1 -> two bubbles (NOP 0x00000013, valid=0, fetch_bubble_o=1), then PC 0x4 valid. Address stays 0x4 throughout.
- Ready=1 at PC 0x8 while if_id_en_i=0 for 3 cycles -> req=0, IF/ID holds. On enable, IF/ID={0x8, word}, next request is 0xC.
- Redirect to 0x100 at PC 0x10 with ready=0; ready arrives 2 cycles later -> data discarded, next address 0x100, no instruction from 0x10 reaches IF/ID.
- Redirect to 0x203 in the same cycle as ready=1 -> IF/ID bubble, next address 0x200.
- rst asserted mid-request at PC 0x40 -> outputs reset immediately. After release, fetch restarts at RESET_PC. With FETCH_PERF_EN, both counters read 0.
